// File: rtl/al_accel_pkg.sv
// Shared types and defaults for the distributed-arithmetic accumulator slice.
// State encoding, default widths and LUT geometry live here so ctrl, top and bench agree.
package al_accel_pkg;

  localparam int WBITS_DEF = 7;
  localparam int ACC_W_DEF = 32;
  localparam int N_CH      = 3;
  localparam int LUT_N     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACCUM,
    ST_OUT
  } state_t;

endpackage

// File: rtl/al_accel_dacc_if.sv
// Group-command, LUT and result handshake bundle of the DA accumulator.
// The slave modport is the accumulator; the master modport is its environment.
interface al_accel_dacc_if
  import al_accel_pkg::*;
#(
  parameter int WBITS = WBITS_DEF,
  parameter int ACC_W = ACC_W_DEF
);

  logic                              start;
  logic                              first;
  logic                              last;
  logic [N_CH-1:0][WBITS-1:0]        wmag;
  logic [LUT_N-1:0][ACC_W-1:0]       lut_do;
  logic                              lut_ld_wrn;
  logic                              busy;
  logic                              out_valid;
  logic [ACC_W-1:0]                  out_data;
  logic                              out_ready;

  modport master (
    output start, first, last, wmag, lut_do, out_ready,
    input  lut_ld_wrn, busy, out_valid, out_data
  );

  modport slave (
    input  start, first, last, wmag, lut_do, out_ready,
    output lut_ld_wrn, busy, out_valid, out_data
  );

endinterface

// File: rtl/al_accel_dacc_ctrl.sv
// Group sequencer: IDLE -> LOAD -> ACCUM (WBITS bit-slices, MSB first) -> OUT/IDLE.
// Latches the group's weight magnitudes and flags, and presents the current bit-slice select.
module al_accel_dacc_ctrl
  import al_accel_pkg::*;
#(
  parameter int WBITS = WBITS_DEF,
  parameter int CNT_W = (WBITS > 1) ? $clog2(WBITS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enb,
  input  logic                       start,
  input  logic                       first,
  input  logic                       last,
  input  logic [N_CH-1:0][WBITS-1:0] wmag,
  input  logic                       out_ready,
  output state_t                     state,
  output logic [CNT_W-1:0]           cnt,
  output logic [N_CH-1:0]            sel,
  output logic                       first_q,
  output logic                       last_q,
  output logic                       lut_ld_wrn,
  output logic                       busy
);

  logic [N_CH-1:0][WBITS-1:0] w_q;

  // NOTE: every register here uses <= so all updates see the pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      w_q        <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      lut_ld_wrn <= 1'b0;
      busy       <= 1'b0;
    end else if (enb) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            w_q        <= wmag;
            first_q    <= first;
            last_q     <= last;
            state      <= ST_LOAD;
            lut_ld_wrn <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_LOAD: begin
          cnt        <= CNT_W'(WBITS - 1);
          state      <= ST_ACCUM;
          lut_ld_wrn <= 1'b0;
        end
        ST_ACCUM: begin
          if (cnt == '0) begin
            if (last_q) begin
              state <= ST_OUT;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_OUT: begin
          // A start arriving with the accept is dropped: state is not IDLE this cycle.
          if (out_ready) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: sel gets a full default before the loop so no latch can be inferred.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_CH; i++) sel[i] = w_q[i][cnt];
  end

endmodule

// File: rtl/al_accel_dacc.sv
// Distributed-arithmetic accumulator: shift-accumulates LUT partial sums per bit-slice,
// sums groups into a dot product and presents it on a valid/ready port.
module al_accel_dacc
  import al_accel_pkg::*;
#(
  parameter int WBITS = WBITS_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enb,
  al_accel_dacc_if.slave  bus
);

  localparam int CNT_W = (WBITS > 1) ? $clog2(WBITS) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [N_CH-1:0]    sel;
  logic               first_q;
  logic               last_q;
  logic               lut_ld_wrn;
  logic               busy;

  logic [ACC_W-1:0]   psum;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   out_data;
  logic               out_valid;
  logic [ACC_W-1:0]   psum_next;
  logic [ACC_W-1:0]   acc_next;

  al_accel_dacc_ctrl #(
    .WBITS (WBITS),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .start      (bus.start),
    .first      (bus.first),
    .last       (bus.last),
    .wmag       (bus.wmag),
    .out_ready  (bus.out_ready),
    .state      (state),
    .cnt        (cnt),
    .sel        (sel),
    .first_q    (first_q),
    .last_q     (last_q),
    .lut_ld_wrn (lut_ld_wrn),
    .busy       (busy)
  );

  // Two's-complement wrap: the shift drops the MSB, the adds discard the carry.
  assign psum_next = (psum << 1) + bus.lut_do[sel];
  assign acc_next  = (first_q ? '0 : acc) + psum_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psum      <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (enb) begin
      case (state)
        ST_LOAD: psum <= '0;
        ST_ACCUM: begin
          psum <= psum_next;
          if (cnt == '0) begin
            acc <= acc_next;
            if (last_q) begin
              out_valid <= 1'b1;
              out_data  <= acc_next;
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.lut_ld_wrn = lut_ld_wrn;
  assign bus.busy       = busy;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;

endmodule
